// File: rtl/apb_master.sv
// apb_master: valid/ready request port to APB SETUP/ACCESS requester with pready timeout
// Ports: pclk/preset clock and async active-high reset; req_valid/req_ready/req_write/
// req_addr/req_wdata request side; rsp_valid/rsp_err/rsp_rdata completion side;
// pselx/penable/pwrite/paddr/pwdata/prdata/pready APB side. All outputs are registered.
module apb_master #(
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 8,
  parameter int TIMEOUT = 16
) (
  input  logic              pclk,
  input  logic              preset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic              rsp_err,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              pselx,
  output logic              penable,
  output logic              pwrite,
  output logic [ADDR_W-1:0] paddr,
  output logic [DATA_W-1:0] pwdata,
  input  logic [DATA_W-1:0] prdata,
  input  logic              pready
);
  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] SETUP  = 2'd1;
  localparam logic [1:0] ACCESS = 2'd2;
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [1:0]    state, state_n;
  logic [CW-1:0] cnt;
  logic          hs, done, tmo;
  assign hs   = req_valid & req_ready;
  assign done = (state == ACCESS) & pready;
  // the edge ending the TIMEOUT-th ACCESS cycle sees cnt == TIMEOUT-1
  assign tmo  = (state == ACCESS) & ~pready & (cnt == CW'(TIMEOUT - 1));
  always_comb
    state_n = (state == IDLE)   ? (hs ? SETUP : IDLE) :
              (state == SETUP)  ? ACCESS :
              (state == ACCESS) ? ((done | tmo) ? IDLE : ACCESS) : IDLE;
  // bus/handshake outputs are decoded from the next state so they stay registered
  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      state     <= IDLE;
      cnt       <= '0;
      req_ready <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_rdata <= '0;
      pselx     <= 1'b0;
      penable   <= 1'b0;
      pwrite    <= 1'b0;
      paddr     <= '0;
      pwdata    <= '0;
    end else begin
      state     <= state_n;
      req_ready <= state_n == IDLE;
      pselx     <= state_n != IDLE;
      penable   <= state_n == ACCESS;
      rsp_valid <= done | tmo;
      if (hs) begin
        pwrite <= req_write;
        paddr  <= req_addr;
        pwdata <= req_wdata;
        cnt    <= '0;
      end else if (state == ACCESS && !pready && !tmo) begin
        cnt <= cnt + 1'b1;
      end
      if (done) begin
        rsp_err <= 1'b0;
        if (!pwrite) rsp_rdata <= prdata;
      end else if (tmo) begin
        rsp_err   <= 1'b1;
        rsp_rdata <= '0;
      end
    end
  end
endmodule

// File: tb/tb_apb_master.sv
// tb_apb_master: directed self-checking bench for apb_master against a wait-state APB slave model
module tb_apb_master;
  logic       pclk = 0, preset = 0, req_valid = 0, req_write = 0;
  logic [7:0] req_addr = 0, req_wdata = 0;
  logic       req_ready, rsp_valid, rsp_err, pselx, penable, pwrite, pready;
  logic [7:0] rsp_rdata, paddr, pwdata, prdata;
  int         n_chk = 0, n_fail = 0, waits = 0, acc_cnt;
  int         k, ps, pe;
  logic [7:0] mem [256];
  always #5 pclk = ~pclk;
  apb_master dut (
    .pclk(pclk), .preset(preset), .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_err(rsp_err), .rsp_rdata(rsp_rdata),
    .pselx(pselx), .penable(penable), .pwrite(pwrite), .paddr(paddr),
    .pwdata(pwdata), .prdata(prdata), .pready(pready)
  );
  assign pready = pselx && penable && (acc_cnt >= waits);
  assign prdata = mem[paddr];
  always @(posedge pclk or posedge preset) begin
    if (preset) acc_cnt <= 0;
    else begin
      acc_cnt <= (pselx && penable && !pready) ? acc_cnt + 1 : 0;
      if (pselx && penable && pready && pwrite) mem[paddr] <= pwdata;
    end
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic issue(input logic w, input logic [7:0] a, input logic [7:0] d);
    req_valid = 1; req_write = w; req_addr = a; req_wdata = d;
    @(posedge pclk); #1;
    req_valid = 0;
    chk("setup_psel", pselx, 1);
    chk("setup_pen", penable, 0);
    chk("setup_addr", paddr, a);
    chk("setup_pwrite", pwrite, w);
    if (w) chk("setup_wdata", pwdata, d);
    chk("setup_rdy", req_ready, 0);
  endtask
  task automatic wait_rsp(input int max, input logic w, input logic [7:0] a, input logic [7:0] d,
                          input logic toggle, output int kk, output int pss, output int pee);
    kk = 0; pss = 1; pee = 0;
    while (kk < max) begin
      @(posedge pclk); #1;
      kk++;
      if (rsp_valid) break;
      if (pselx) pss++;
      if (penable) pee++;
      chk("hold_addr", paddr, a);
      chk("hold_pwrite", pwrite, w);
      if (w) chk("hold_wdata", pwdata, d);
      chk("busy_rdy", req_ready, 0);
      if (toggle) begin
        req_valid = 1'($urandom_range(0, 1));
        req_write = 1'($urandom_range(0, 1));
        req_addr  = 8'($urandom);
        req_wdata = 8'($urandom);
      end
    end
    if (toggle) req_valid = 0;
    chk("rsp_seen", rsp_valid, 1);
  endtask
  initial begin
    #2 preset = 1;
    #1;
    chk("rst_rdy", req_ready, 0);
    chk("rst_psel", pselx, 0);
    chk("rst_pen", penable, 0);
    chk("rst_rsp", rsp_valid, 0);
    chk("rst_rdata", rsp_rdata, 0);
    chk("rst_paddr", paddr, 0);
    @(negedge pclk); @(negedge pclk);
    preset = 0;
    @(posedge pclk); #1;
    chk("rdy_after_rst", req_ready, 1);
    // write 0xA5 to 0x3C, zero wait
    issue(1, 8'h3C, 8'hA5);
    wait_rsp(40, 1, 8'h3C, 8'hA5, 0, k, ps, pe);
    chk("wr_lat", k, 2);
    chk("wr_psel_cyc", ps, 2);
    chk("wr_pen_cyc", pe, 1);
    chk("wr_err", rsp_err, 0);
    chk("wr_rsp_rdy", req_ready, 1);
    chk("wr_rsp_psel", pselx, 0);
    @(posedge pclk); #1;
    chk("wr_pulse", rsp_valid, 0);
    chk("wr_mem", mem[8'h3C], 8'hA5);
    // read it back
    issue(0, 8'h3C, 8'h00);
    wait_rsp(40, 0, 8'h3C, 8'h00, 0, k, ps, pe);
    chk("rd_lat", k, 2);
    chk("rd_psel_cyc", ps, 2);
    chk("rd_pen_cyc", pe, 1);
    chk("rd_err", rsp_err, 0);
    chk("rd_data", rsp_rdata, 8'hA5);
    @(posedge pclk); #1;
    chk("rd_pulse", rsp_valid, 0);
    chk("rd_hold", rsp_rdata, 8'hA5);
    // 15 wait cycles then ready
    issue(1, 8'h77, 8'h5A);
    wait_rsp(40, 1, 8'h77, 8'h5A, 0, k, ps, pe);
    chk("wr77_rdata_kept", rsp_rdata, 8'hA5);
    waits = 15;
    @(posedge pclk); #1;
    issue(0, 8'h77, 8'h00);
    wait_rsp(40, 0, 8'h77, 8'h00, 0, k, ps, pe);
    chk("w15_lat", k, 17);
    chk("w15_pen_cyc", pe, 16);
    chk("w15_err", rsp_err, 0);
    chk("w15_data", rsp_rdata, 8'h5A);
    // 16 wait cycles -> timeout
    waits = 16;
    @(posedge pclk); #1;
    issue(0, 8'h77, 8'h00);
    wait_rsp(40, 0, 8'h77, 8'h00, 0, k, ps, pe);
    chk("to_lat", k, 17);
    chk("to_pen_cyc", pe, 16);
    chk("to_err", rsp_err, 1);
    chk("to_data", rsp_rdata, 8'h00);
    chk("to_psel", pselx, 0);
    @(posedge pclk); #1;
    chk("to_pulse", rsp_valid, 0);
    chk("to_psel_next", pselx, 0);
    chk("to_err_hold", rsp_err, 1);
    // back-to-back: next request held from SETUP, accepted in the rsp_valid cycle
    waits = 0;
    issue(1, 8'h20, 8'h11);
    req_valid = 1; req_write = 1; req_addr = 8'h21; req_wdata = 8'h22;
    wait_rsp(40, 1, 8'h20, 8'h11, 0, k, ps, pe);
    chk("b2b_lat1", k, 2);
    chk("b2b_err", rsp_err, 0);
    chk("b2b_rdy", req_ready, 1);
    @(posedge pclk); #1;
    req_valid = 0;
    chk("b2b_psel", pselx, 1);
    chk("b2b_pen", penable, 0);
    chk("b2b_addr", paddr, 8'h21);
    chk("b2b_wdata", pwdata, 8'h22);
    chk("b2b_pulse", rsp_valid, 0);
    wait_rsp(40, 1, 8'h21, 8'h22, 0, k, ps, pe);
    chk("b2b_lat2", k, 2);
    chk("b2b_mem20", mem[8'h20], 8'h11);
    chk("b2b_mem21", mem[8'h21], 8'h22);
    // random req_valid noise during a 3-wait read
    waits = 3;
    @(posedge pclk); #1;
    issue(1, 8'h40, 8'h5C);
    wait_rsp(40, 1, 8'h40, 8'h5C, 1, k, ps, pe);
    chk("tg_wr_lat", k, 5);
    @(posedge pclk); #1;
    issue(0, 8'h40, 8'h00);
    wait_rsp(40, 0, 8'h40, 8'h00, 1, k, ps, pe);
    chk("tg_rd_lat", k, 5);
    chk("tg_psel_cyc", ps, 5);
    chk("tg_pen_cyc", pe, 4);
    chk("tg_data", rsp_rdata, 8'h5C);
    for (int i = 0; i < 3; i++) begin
      @(posedge pclk); #1;
      chk("tg_no_extra_rsp", rsp_valid, 0);
      chk("tg_no_extra_psel", pselx, 0);
    end
    // reset mid-ACCESS with pready low
    waits = 16;
    issue(0, 8'h3C, 8'h00);
    @(posedge pclk); #1;
    @(posedge pclk); #1;
    chk("mid_pen", penable, 1);
    #2 preset = 1;
    #1;
    chk("ar_psel", pselx, 0);
    chk("ar_pen", penable, 0);
    chk("ar_rsp", rsp_valid, 0);
    chk("ar_rdy", req_ready, 0);
    @(posedge pclk); #3;
    preset = 0;
    @(posedge pclk); #1;
    chk("ar_rdy_rel", req_ready, 1);
    chk("ar_psel_rel", pselx, 0);
    for (int i = 0; i < 3; i++) begin
      @(posedge pclk); #1;
      chk("ar_no_rsp", rsp_valid, 0);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
